// File: rtl/rr_sel_2bit_pkg.sv
// Shared definitions for the rr_sel_2bit arbiter: output-stage state and grant encodings.
`ifndef RR_SEL_2BIT
`define RR_SEL_2BIT

package rr_sel_2bit_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic GRANT_CH1 = 1'b0;
  localparam logic GRANT_CH2 = 1'b1;

endpackage

`endif

// File: rtl/rr_sel_2bit_mux2_1_2bit.sv
// 2:1 multiplexer for 2-bit words; selec_2bit=0 picks in1, 1 picks in2.
module mux2_1_2bit (
  input  logic       selec_2bit,
  input  logic [1:0] in1,
  input  logic [1:0] in2,
  output logic [1:0] out
);

  assign out = selec_2bit ? in2 : in1;

endmodule

// File: rtl/rr_sel_2bit.sv
// Two-channel round-robin arbiter feeding a single-entry registered output stage.
// Optional per-channel saturating grant counters when RR_STATS_EN is defined.
module rr_sel_2bit
  import rr_sel_2bit_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             in1_valid,
  input  logic [1:0]       in1_data,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [1:0]       in2_data,
  output logic             in2_ready,
  output logic             out_valid,
  output logic [1:0]       out_data,
  input  logic             out_ready,
  output logic             selec_2bit
`ifdef RR_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] grant_cnt2
`endif
);

  state_e     state_p1;
  logic       last_grant;
  logic       can_load;
  logic       load;
  logic [1:0] mux_out;

  always_comb begin
    selec_2bit = last_grant;
    unique case ({in2_valid, in1_valid})
      2'b01:   selec_2bit = GRANT_CH1;
      2'b10:   selec_2bit = GRANT_CH2;
      2'b11:   selec_2bit = ~last_grant;
      default: selec_2bit = last_grant;
    endcase
  end

  // Gating with reset_L keeps both producers stalled while reset is held.
  assign can_load  = (state_p1 == ST_EMPTY) | out_ready;
  assign load      = reset_L & can_load & (in1_valid | in2_valid);
  assign in1_ready = load & (selec_2bit == GRANT_CH1);
  assign in2_ready = load & (selec_2bit == GRANT_CH2);

  mux2_1_2bit u_mux (
    .selec_2bit (selec_2bit),
    .in1        (in1_data),
    .in2        (in2_data),
    .out        (mux_out)
  );

  // Output stage boundary: accepted word registered here, visible next cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_p1   <= ST_EMPTY;
      last_grant <= GRANT_CH2;
      out_data   <= 2'b00;
    end else if (load) begin
      state_p1   <= ST_FULL;
      last_grant <= selec_2bit;
      out_data   <= mux_out;
    end else if (out_ready) begin
      state_p1   <= ST_EMPTY;
    end
  end

  assign out_valid = (state_p1 == ST_FULL);

`ifdef RR_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      grant_cnt1 <= '0;
      grant_cnt2 <= '0;
    end else begin
      if (in1_ready) grant_cnt1 <= sat_inc(grant_cnt1);
      if (in2_ready) grant_cnt2 <= sat_inc(grant_cnt2);
    end
  end
`endif

endmodule

// File: tb/tb_rr_sel_2bit.sv
// Bench for rr_sel_2bit: vector table plus hand sequences, scoreboard queue for output words.
module tb_rr_sel_2bit;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       in1_valid, in2_valid, out_ready;
  logic [1:0] in1_data, in2_data;
  logic       in1_ready, in2_ready, out_valid, selec_2bit;
  logic [1:0] out_data;
`ifdef RR_STATS_EN
  logic [1:0] grant_cnt1, grant_cnt2;
`endif

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_q[$];

  typedef struct {
    logic       v1;
    logic [1:0] d1;
    logic       v2;
    logic [1:0] d2;
    logic       r1;
    logic       r2;
    logic       sel;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  rr_sel_2bit #(.CNT_W(2)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .in1_valid  (in1_valid),
    .in1_data   (in1_data),
    .in1_ready  (in1_ready),
    .in2_valid  (in2_valid),
    .in2_data   (in2_data),
    .in2_ready  (in2_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .selec_2bit (selec_2bit)
`ifdef RR_STATS_EN
    ,
    .grant_cnt1 (grant_cnt1),
    .grant_cnt2 (grant_cnt2)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v1, input logic [1:0] d1, input logic v2,
                       input logic [1:0] d2, input logic ordy);
    in1_valid = v1;
    in1_data  = d1;
    in2_valid = v2;
    in2_data  = d2;
    out_ready = ordy;
  endtask

  // Check the combinational handshake, push the word expected to be accepted.
  task automatic cycle(input string name, input logic er1, input logic er2, input logic esel,
                       input logic pop_expect);
    logic pushed;
    #1;
    chk({name, "_sel"}, {7'd0, selec_2bit}, {7'd0, esel});
    chk({name, "_in1_ready"}, {7'd0, in1_ready}, {7'd0, er1});
    chk({name, "_in2_ready"}, {7'd0, in2_ready}, {7'd0, er2});
    pushed = 1'b0;
    if (er1) begin exp_q.push_back(in1_data); pushed = 1'b1; end
    else if (er2) begin exp_q.push_back(in2_data); pushed = 1'b1; end
    @(posedge clk);
    #1;
    if (pushed) begin
      chk({name, "_out_valid"}, {7'd0, out_valid}, 8'd1);
      if (exp_q.size() == 0) chk({name, "_scoreboard_empty"}, 8'd0, 8'd1);
      else chk({name, "_out_data"}, {6'd0, out_data}, {6'd0, exp_q.pop_front()});
    end else if (pop_expect) begin
      chk({name, "_out_valid_idle"}, {7'd0, out_valid}, 8'd0);
    end
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    drive(1'b1, 2'b11, 1'b1, 2'b01, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {7'd0, out_valid}, 8'd0);
    chk("reset_in1_ready", {7'd0, in1_ready}, 8'd0);
    chk("reset_in2_ready", {7'd0, in2_ready}, 8'd0);
    chk("reset_out_data", {6'd0, out_data}, 8'd0);
    exp_q.delete();
    @(negedge clk);
    reset_L = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'b00, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'b10, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1};

    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    do_reset();

    // Table vectors with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, 1'b1);
      cycle($sformatf("vec%0d", i), tbl[i].r1, tbl[i].r2, tbl[i].sel, 1'b1);
    end

    // Backpressure: load 10, then stall three cycles with both producers waiting.
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 2'b00, 1'b1);
    cycle("bp_load", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 2'b01, 1'b1, 2'b11, 1'b0);
      cycle($sformatf("bp_stall%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("bp_hold_valid%0d", i), {7'd0, out_valid}, 8'd1);
      chk($sformatf("bp_hold_data%0d", i), {6'd0, out_data}, 8'h02);
    end
    @(negedge clk);
    drive(1'b1, 2'b01, 1'b1, 2'b11, 1'b1);
    cycle("bp_rel0", 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    cycle("bp_rel1", 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    cycle("bp_drain", 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset between edges while FULL.
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b1, 2'b11, 1'b0);
    cycle("ar_fill", 1'b0, 1'b1, 1'b1, 1'b1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("ar_out_valid", {7'd0, out_valid}, 8'd0);
    chk("ar_out_data", {6'd0, out_data}, 8'd0);
    chk("ar_in2_ready", {7'd0, in2_ready}, 8'd0);
    @(negedge clk);
    reset_L = 1'b1;
    drive(1'b1, 2'b01, 1'b1, 2'b11, 1'b1);
    cycle("ar_first", 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    cycle("ar_second", 1'b0, 1'b1, 1'b1, 1'b1);

`ifdef RR_STATS_EN
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b0, 2'b00, 1'b1, 2'(i), 1'b1);
      cycle($sformatf("st_ch2_%0d", i), 1'b0, 1'b1, 1'b1, 1'b1);
    end
    chk("st_grant_cnt2", {6'd0, grant_cnt2}, 8'd3);
    chk("st_grant_cnt1", {6'd0, grant_cnt1}, 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
